// File: rtl/pipe_ctrl_fsm.sv
// Pipeline control FSM: PC/IR load enables, IR1 fetch/NOP select and cycle-counter enable,
// with branch stall, pipeline freeze on hazard and a resumable halt.
module pipe_ctrl_fsm #(
  parameter int unsigned         NSTAGES  = 4,
  parameter int unsigned         OPW      = 4,
  parameter int unsigned         BR_STALL = 3,
  parameter logic [2**OPW-1:0]   BR_OPS   = 16'h2220,
  parameter logic [OPW-1:0]      OP_STOP  = 4'b0001
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [OPW-1:0]     instr,
  input  logic               hazard,
  input  logic               resume,
  output logic               pc_write,
  output logic [NSTAGES-1:0] pc_load,
  output logic [NSTAGES-1:0] ir_load,
  output logic               ir1_sel,
  output logic               counter_on,
  output logic               halted,
  output logic [2:0]         state_o
);

  localparam int unsigned   CW         = (BR_STALL > 1) ? $clog2(BR_STALL) : 1;
  // Counter counts down to zero, so BR_WAIT spans BR_STALL-1 cycles.
  localparam logic [CW-1:0] STALL_INIT = CW'(BR_STALL - 2);

  typedef enum logic [2:0] {
    StRst    = 3'd0,
    StRun    = 3'd1,
    StBrWait = 3'd2,
    StBrRel  = 3'd3,
    StHalt   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_all;
  logic          is_branch;
  logic          legal_active;

  assign is_branch    = BR_OPS[instr] && (instr != OP_STOP);
  assign legal_active = (state_q == StRun) || (state_q == StBrWait) ||
                        (state_q == StBrRel) || (state_q == StHalt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b0;
    load_all   = 1'b0;
    ir1_sel    = 1'b0;
    counter_on = 1'b0;
    halted     = 1'b0;

    case (state_q)
      StRst: begin
        ir1_sel = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        pc_write   = 1'b1;
        load_all   = 1'b1;
        ir1_sel    = 1'b1;
        counter_on = 1'b1;
        if (instr == OP_STOP) begin
          state_d = StHalt;
        end else if (is_branch) begin
          pc_write = 1'b0;
          cnt_d    = STALL_INIT;
          state_d  = StBrWait;
        end
      end
      StBrWait: begin
        load_all = 1'b1;
        if (cnt_q == '0) begin
          state_d = StBrRel;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StBrRel: begin
        pc_write   = 1'b1;
        load_all   = 1'b1;
        ir1_sel    = 1'b1;
        counter_on = 1'b1;
        state_d    = StRun;
      end
      StHalt: begin
        load_all = 1'b1;
        halted   = 1'b1;
        if (resume) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRst;
      end
    endcase

    // Freeze: kill writes/loads and hold all state; select/enable/halted keep the state's value.
    if (hazard && legal_active) begin
      pc_write = 1'b0;
      load_all = 1'b0;
      state_d  = state_q;
      cnt_d    = cnt_q;
    end
  end

  assign pc_load = {NSTAGES{load_all}};
  assign ir_load = {NSTAGES{load_all}};
  assign state_o = state_q;

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Scoreboard bench for pipe_ctrl_fsm: default instance (4 stages, stall 3) and a
// 6-stage / stall-5 instance; expected output vectors are queued per driven cycle.
module tb_pipe_ctrl_fsm;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: defaults
  logic       rst_a, haz_a, res_a;
  logic [3:0] ins_a;
  logic       pw_a, sel_a, con_a, hlt_a;
  logic [3:0] pcl_a, irl_a;
  logic [2:0] st_a;

  // Instance B: NSTAGES=6, BR_STALL=5
  logic       rst_b, haz_b, res_b;
  logic [3:0] ins_b;
  logic       pw_b, sel_b, con_b, hlt_b;
  logic [5:0] pcl_b, irl_b;
  logic [2:0] st_b;

  pipe_ctrl_fsm u_dut_a (
    .clock     (clock),
    .reset     (rst_a),
    .instr     (ins_a),
    .hazard    (haz_a),
    .resume    (res_a),
    .pc_write  (pw_a),
    .pc_load   (pcl_a),
    .ir_load   (irl_a),
    .ir1_sel   (sel_a),
    .counter_on(con_a),
    .halted    (hlt_a),
    .state_o   (st_a)
  );

  pipe_ctrl_fsm #(
    .NSTAGES (6),
    .BR_STALL(5)
  ) u_dut_b (
    .clock     (clock),
    .reset     (rst_b),
    .instr     (ins_b),
    .hazard    (haz_b),
    .resume    (res_b),
    .pc_write  (pw_b),
    .pc_load   (pcl_b),
    .ir_load   (irl_b),
    .ir1_sel   (sel_b),
    .counter_on(con_b),
    .halted    (hlt_b),
    .state_o   (st_b)
  );

  typedef struct {
    string       tag;
    bit          which;
    logic [22:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        n_checks = 0;
  int        n_errors = 0;

  // Packed view: {pc_write, pc_load[7:0], ir_load[7:0], ir1_sel, counter_on, halted, state}
  function automatic logic [22:0] ev(bit pw, bit ld, int nst, bit sel, bit con, bit h,
                                     logic [2:0] st);
    logic [7:0] m;
    m = ld ? 8'((1 << nst) - 1) : 8'h00;
    return {pw, m, m, sel, con, h, st};
  endfunction

  task automatic check_eq(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  logic [22:0] obs_a, obs_b;
  assign obs_a = {pw_a, 4'h0, pcl_a, 4'h0, irl_a, sel_a, con_a, hlt_a, st_a};
  assign obs_b = {pw_b, 2'h0, pcl_b, 2'h0, irl_b, sel_b, con_b, hlt_b, st_b};

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      check_eq(e.tag, e.which ? obs_b : obs_a, e.exp);
    end
  end

  task automatic step(input string tag, input bit which, input bit rst, input logic [3:0] ins,
                      input bit hz, input bit rs, input logic [22:0] exp);
    sb_entry_t e;
    if (which) begin
      rst_b = rst; ins_b = ins; haz_b = hz; res_b = rs;
    end else begin
      rst_a = rst; ins_a = ins; haz_a = hz; res_a = rs;
    end
    e.tag = tag; e.which = which; e.exp = exp;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, pending %0d", sb.size());
    $fatal(1);
  end

  initial begin
    logic [22:0] e_rst, e_run, e_brd, e_brw, e_brr, e_hlt, e_hz_run, e_hz_brw, e_hz_hlt;
    logic [22:0] b_rst, b_run, b_brd, b_brw, b_brr;

    e_rst    = ev(0, 0, 4, 1, 0, 0, 3'd0);
    e_run    = ev(1, 1, 4, 1, 1, 0, 3'd1);
    e_brd    = ev(0, 1, 4, 1, 1, 0, 3'd1);
    e_brw    = ev(0, 1, 4, 0, 0, 0, 3'd2);
    e_brr    = ev(1, 1, 4, 1, 1, 0, 3'd3);
    e_hlt    = ev(0, 1, 4, 0, 0, 1, 3'd4);
    e_hz_run = ev(0, 0, 4, 1, 1, 0, 3'd1);
    e_hz_brw = ev(0, 0, 4, 0, 0, 0, 3'd2);
    e_hz_hlt = ev(0, 0, 4, 0, 0, 1, 3'd4);
    b_rst    = ev(0, 0, 6, 1, 0, 0, 3'd0);
    b_run    = ev(1, 1, 6, 1, 1, 0, 3'd1);
    b_brd    = ev(0, 1, 6, 1, 1, 0, 3'd1);
    b_brw    = ev(0, 1, 6, 0, 0, 0, 3'd2);
    b_brr    = ev(1, 1, 6, 1, 1, 0, 3'd3);

    rst_a = 0; ins_a = 0; haz_a = 0; res_a = 0;
    rst_b = 0; ins_b = 0; haz_b = 0; res_b = 0;
    @(posedge clock);
    #1;

    // T1: reset held, then release
    step("t1_rst0", 0, 0, 4'h0, 0, 0, e_rst);
    step("t1_rst1", 0, 0, 4'h0, 0, 0, e_rst);
    step("t1_rel",  0, 1, 4'h0, 0, 0, e_rst);
    step("t1_run",  0, 1, 4'h0, 0, 0, e_run);
    step("t1_run2", 0, 1, 4'h2, 0, 1, e_run); // resume ignored in RUN
    step("t1_run3", 0, 1, 4'hF, 0, 0, e_run);

    // T2: branch opcode 5
    step("t2_c0", 0, 1, 4'h5, 0, 0, e_brd);
    step("t2_c1", 0, 1, 4'h0, 0, 0, e_brw);
    step("t2_c2", 0, 1, 4'h5, 0, 0, e_brw);
    step("t2_c3", 0, 1, 4'h0, 0, 0, e_brr);
    step("t2_c4", 0, 1, 4'h0, 0, 0, e_run);

    // T3: stop, long halt, hazard blocks resume, then resume
    step("t3_stop", 0, 1, 4'h1, 0, 0, e_run);
    for (int i = 0; i < 20; i++) step("t3_halt", 0, 1, 4'(i), 0, 0, e_hlt);
    step("t3_hz_res", 0, 1, 4'h0, 1, 1, e_hz_hlt);
    step("t3_res",    0, 1, 4'h0, 0, 1, e_hlt);
    step("t3_run",    0, 1, 4'h0, 0, 0, e_run);

    // T4: hazard during BR_WAIT stretches the stall
    step("t4_c0", 0, 1, 4'hD, 0, 0, e_brd);
    step("t4_c1", 0, 1, 4'h0, 0, 0, e_brw);
    step("t4_c2", 0, 1, 4'h0, 1, 0, e_hz_brw);
    step("t4_c3", 0, 1, 4'h0, 1, 0, e_hz_brw);
    step("t4_c4", 0, 1, 4'h0, 0, 0, e_brw);
    step("t4_c5", 0, 1, 4'h0, 0, 0, e_brr);
    step("t4_c6", 0, 1, 4'h0, 0, 0, e_run);

    // T5: hazard masks a branch opcode in RUN
    for (int i = 0; i < 3; i++) step("t5_hz", 0, 1, 4'h9, 1, 0, e_hz_run);
    step("t5_br",  0, 1, 4'h9, 0, 0, e_brd);
    step("t5_w1",  0, 1, 4'h0, 0, 0, e_brw);
    step("t5_w2",  0, 1, 4'h0, 0, 0, e_brw);
    step("t5_rel", 0, 1, 4'h0, 0, 0, e_brr);
    step("t5_run", 0, 1, 4'h1, 1, 0, e_hz_run); // hazard also masks stop
    step("t5_run2", 0, 1, 4'h0, 0, 0, e_run);

    // T6: reset in BR_WAIT
    step("t6_br",   0, 1, 4'h5, 0, 0, e_brd);
    step("t6_rstw", 0, 0, 4'h0, 0, 0, e_brw);
    step("t6_rst",  0, 1, 4'h0, 0, 0, e_rst);
    step("t6_run",  0, 1, 4'h0, 0, 0, e_run);

    // T6b: wide instance, BR_STALL=5 -> 4 BR_WAIT cycles
    step("b_rel", 1, 1, 4'h0, 0, 0, b_rst);
    step("b_run", 1, 1, 4'h0, 0, 0, b_run);
    step("b_br",  1, 1, 4'h5, 0, 0, b_brd);
    for (int i = 0; i < 4; i++) step("b_wait", 1, 1, 4'h0, 0, 0, b_brw);
    step("b_brr",  1, 1, 4'h0, 0, 0, b_brr);
    step("b_run2", 1, 1, 4'h0, 0, 0, b_run);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
